// File: rtl/tensor_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tensor_pkg
// Shared types and default geometry for the tensor load controller and its
// address generator.
//   tlc_state_t : controller states (LOAD, DRAIN, HOLD)
//   TENSOR_*    : default tensor geometry and element width
//   *_AW        : builder address widths (row / column / channel)
//   CNT_W       : width of the element and frame counters
// ---------------------------------------------------------------------------
package tensor_pkg;
  localparam int TENSOR_ROWS  = 8;
  localparam int TENSOR_COLS  = 8;
  localparam int TENSOR_CHANS = 3;
  localparam int TENSOR_WIDTH = 17;

  localparam int ROW_AW = 3;
  localparam int COL_AW = 3;
  localparam int CHA_AW = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } tlc_state_t;
endpackage

// File: rtl/tensor_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// tensor_load_ctrl_if
// Bundles the three handshakes around the load controller:
//   element stream : s_valid, s_ready, s_data
//   builder write  : wr_en, row_addr, col_addr, cha_addr, wr_data
//   tensor handoff : tensor_valid, tensor_ready
// Modports:
//   slave  : the controller's view (consumes the stream, drives the builder)
//   master : the environment's view (source, builder and consumer side)
// ---------------------------------------------------------------------------
interface tensor_load_ctrl_if #(
  parameter int WIDTH = tensor_pkg::TENSOR_WIDTH
);
  import tensor_pkg::*;

  logic                s_valid;
  logic                s_ready;
  logic [WIDTH-1:0]    s_data;
  logic                wr_en;
  logic [ROW_AW-1:0]   row_addr;
  logic [COL_AW-1:0]   col_addr;
  logic [CHA_AW-1:0]   cha_addr;
  logic [WIDTH-1:0]    wr_data;
  logic                tensor_valid;
  logic                tensor_ready;

  modport slave (
    input  s_valid, s_data, tensor_ready,
    output s_ready, wr_en, row_addr, col_addr, cha_addr, wr_data, tensor_valid
  );

  modport master (
    output s_valid, s_data, tensor_ready,
    input  s_ready, wr_en, row_addr, col_addr, cha_addr, wr_data, tensor_valid
  );
endinterface

// File: rtl/tensor_load_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// tensor_addr_gen
// Nested raster counter: channel fastest, then column, then row. Wraps the
// whole tensor back to (0,0,0) after the last position.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   i_inc    : advance one position
//   i_clr    : return to (0,0,0); wins over i_inc
//   o_row/o_col/o_cha : current position
//   o_last   : current position is the final one of the tensor
// ---------------------------------------------------------------------------
module tensor_addr_gen
  import tensor_pkg::*;
#(
  parameter int ROWS  = TENSOR_ROWS,
  parameter int COLS  = TENSOR_COLS,
  parameter int CHANS = TENSOR_CHANS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [ROW_AW-1:0] o_row,
  output logic [COL_AW-1:0] o_col,
  output logic [CHA_AW-1:0] o_cha,
  output logic              o_last
);
  logic [ROW_AW-1:0] r_row;
  logic [COL_AW-1:0] r_col;
  logic [CHA_AW-1:0] r_cha;
  logic              w_row_last;
  logic              w_col_last;
  logic              w_cha_last;

  assign w_row_last = (r_row == ROW_AW'(ROWS - 1));
  assign w_col_last = (r_col == COL_AW'(COLS - 1));
  assign w_cha_last = (r_cha == CHA_AW'(CHANS - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
      r_cha <= '0;
    end else if (i_inc) begin
      if (!w_cha_last) begin
        r_cha <= r_cha + 1'b1;
      end else begin
        r_cha <= '0;
        if (!w_col_last) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_cha  = r_cha;
  assign o_last = w_row_last && w_col_last && w_cha_last;
endmodule

// File: rtl/tensor_load_ctrl.sv
// ---------------------------------------------------------------------------
// tensor_load_ctrl
// Fills the tensor builder from a valid/ready element stream in raster order
// (channel fastest), then presents the completed tensor to a consumer and
// stalls the stream until the consumer takes it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : tensor_load_ctrl_if.slave (stream in, builder write port,
//                tensor_valid/tensor_ready handoff)
//   elem_cnt   : elements accepted into the current tensor
//   frame_cnt  : tensors handed off, wraps 255 -> 0
//   abort      : only when TENSOR_LOAD_CTRL_ABORT_EN is defined; discards the
//                tensor in progress and returns to LOAD
// ---------------------------------------------------------------------------
module tensor_load_ctrl
  import tensor_pkg::*;
#(
  parameter int WIDTH = TENSOR_WIDTH,
  parameter int ROWS  = TENSOR_ROWS,
  parameter int COLS  = TENSOR_COLS,
  parameter int CHANS = TENSOR_CHANS
) (
  input  logic                  clk,
  input  logic                  rst,
  tensor_load_ctrl_if.slave     bus,
`ifdef TENSOR_LOAD_CTRL_ABORT_EN
  input  logic                  abort,
`endif
  output logic [CNT_W-1:0]      elem_cnt,
  output logic [CNT_W-1:0]      frame_cnt
);
  tlc_state_t        r_state;
  tlc_state_t        w_state_next;

  logic              w_s_ready;
  logic              w_tensor_valid;
  logic              w_accept;
  logic              w_abort;
  logic              w_inc;
  logic              w_last;
  logic [ROW_AW-1:0] w_row;
  logic [COL_AW-1:0] w_col;
  logic [CHA_AW-1:0] w_cha;

  logic              r_wr_en;
  logic [ROW_AW-1:0] r_row_addr;
  logic [COL_AW-1:0] r_col_addr;
  logic [CHA_AW-1:0] r_cha_addr;
  logic [WIDTH-1:0]  r_wr_data;
  logic [CNT_W-1:0]  r_elem_cnt;
  logic [CNT_W-1:0]  r_frame_cnt;

`ifdef TENSOR_LOAD_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = bus.s_valid && w_s_ready;
  // An abort on the same edge drops the element: no write, no advance.
  assign w_inc    = w_accept && !w_abort;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD:    if (w_accept && w_last) w_state_next = DRAIN;
      DRAIN:   w_state_next = HOLD;
      HOLD:    if (bus.tensor_ready) w_state_next = LOAD;
      default: w_state_next = LOAD;
    endcase
    if (w_abort) begin
      w_state_next = LOAD;
    end
  end

  // State decode: ready/valid depend on state only, never on s_valid.
  always_comb begin
    w_s_ready      = (r_state == LOAD);
    w_tensor_valid = (r_state == HOLD);
  end

  tensor_addr_gen #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CHANS (CHANS)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_clr  (w_abort),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_cha  (w_cha),
    .o_last (w_last)
  );

  // Builder write port and counters. The write for an element accepted at
  // edge T is presented during T+1, so the last write lands in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en     <= 1'b0;
      r_row_addr  <= '0;
      r_col_addr  <= '0;
      r_cha_addr  <= '0;
      r_wr_data   <= '0;
      r_elem_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_wr_en <= w_inc;
      if (w_inc) begin
        r_row_addr <= w_row;
        r_col_addr <= w_col;
        r_cha_addr <= w_cha;
        r_wr_data  <= bus.s_data;
      end

      if (w_abort) begin
        r_elem_cnt <= '0;
      end else if (w_inc) begin
        r_elem_cnt <= w_last ? '0 : r_elem_cnt + 1'b1;
      end

      if ((r_state == HOLD) && bus.tensor_ready && !w_abort) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.tensor_valid = w_tensor_valid;
  assign bus.wr_en        = r_wr_en;
  assign bus.row_addr     = r_row_addr;
  assign bus.col_addr     = r_col_addr;
  assign bus.cha_addr     = r_cha_addr;
  assign bus.wr_data      = r_wr_data;
  assign elem_cnt         = r_elem_cnt;
  assign frame_cnt        = r_frame_cnt;
endmodule

// File: tb/tb_tensor_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tensor_load_ctrl
// Randomized bench for tensor_load_ctrl. A default-geometry instance is
// driven against a per-cycle reference model (element index -> address by
// plain arithmetic), and a 1x1x1 instance exercises frame_cnt wrap-around
// with tensor_ready held high. Optional abort tests follow the
// TENSOR_LOAD_CTRL_ABORT_EN macro.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tensor_load_ctrl;
  localparam int W  = 17;
  localparam int NR = 8;
  localparam int NC = 8;
  localparam int NH = 3;
  localparam int N  = NR * NC * NH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rst_s;
  logic       abort_m;
  logic [7:0] elem_cnt, frame_cnt, elem_cnt_s, frame_cnt_s;

  tensor_load_ctrl_if #(.WIDTH(W)) bus ();
  tensor_load_ctrl_if #(.WIDTH(W)) bus_s ();

  tensor_load_ctrl #(.WIDTH(W), .ROWS(NR), .COLS(NC), .CHANS(NH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef TENSOR_LOAD_CTRL_ABORT_EN
    .abort     (abort_m),
`endif
    .elem_cnt  (elem_cnt),
    .frame_cnt (frame_cnt)
  );

  tensor_load_ctrl #(.WIDTH(W), .ROWS(1), .COLS(1), .CHANS(1)) dut_s (
    .clk       (clk),
    .rst       (rst_s),
    .bus       (bus_s),
`ifdef TENSOR_LOAD_CTRL_ABORT_EN
    .abort     (1'b0),
`endif
    .elem_cnt  (elem_cnt_s),
    .frame_cnt (frame_cnt_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0 = accepting, 1 = one cycle after the final
  // accept, 2 = waiting for the consumer.
  int         m_phase;
  int         m_count;
  int         m_frames;
  bit         m_pend;
  int         m_pidx;
  logic [W-1:0] m_pdata;
  int         n_acc;
  int         n_wr;
  int         n_tensor;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic tr,
                      input logic ab, input logic rs);
    int r, c, h;
    bus.s_valid      = v;
    bus.s_data       = d;
    bus.tensor_ready = tr;
    abort_m          = ab;
    rst              = rs;
    @(negedge clk);
    check("s_ready", 64'(bus.s_ready), 64'(m_phase == 0));
    check("tensor_valid", 64'(bus.tensor_valid), 64'(m_phase == 2));
    check("wr_en", 64'(bus.wr_en), 64'(m_pend));
    if (bus.wr_en) n_wr++;
    if (m_pend) begin
      r = m_pidx / (NC * NH);
      c = (m_pidx / NH) % NC;
      h = m_pidx % NH;
      check("wr_addr", 64'({bus.row_addr, bus.col_addr, bus.cha_addr}),
            64'((r << 5) | (c << 2) | h));
      check("wr_data", 64'(bus.wr_data), 64'(m_pdata));
    end
    check("elem_cnt", 64'(elem_cnt), 64'(m_count));
    check("frame_cnt", 64'(frame_cnt), 64'(m_frames % 256));
    @(posedge clk);
    m_pend = 1'b0;
    if (rs || ab) begin
      m_phase = 0;
      m_count = 0;
      if (rs) m_frames = 0;
    end else begin
      case (m_phase)
        0: if (v) begin
             m_pend  = 1'b1;
             m_pidx  = m_count;
             m_pdata = d;
             n_acc++;
             m_count++;
             if (m_count == N) begin
               m_count = 0;
               m_phase = 1;
             end
           end
        1: m_phase = 2;
        default: if (tr) begin
             m_phase = 0;
             m_frames++;
           end
      endcase
    end
    #1;
  endtask

  // Stream until the model says a full tensor was accepted. rst_at/abort_at
  // fire once, on an offered element whose index equals the given value.
  task automatic load_tensor(input int bubble, input bit idx_data,
                             input int rst_at, input int abort_at);
    int guard = 0;
    bit fired = 1'b0;
    logic v, rs, ab;
    logic [W-1:0] d;
    while (m_phase == 0 && guard < 2000) begin
      v  = ($urandom_range(99) >= bubble);
      d  = idx_data ? W'(m_count) : W'($urandom);
      rs = 1'b0;
      ab = 1'b0;
      if (!fired && v && m_count == rst_at) begin rs = 1'b1; fired = 1'b1; end
      if (!fired && v && m_count == abort_at) begin ab = 1'b1; fired = 1'b1; end
      step(v, d, 1'($urandom_range(1)), ab, rs);
      guard++;
    end
    if (guard >= 2000) check("load_timeout", 64'd1, 64'd0);
  endtask

  // DRAIN (with an ignored tensor_ready pulse), hold cycles, then handoff.
  task automatic finish_tensor(input int hold, input bit ab_on_ready);
    check("in_drain", 64'(m_phase), 64'd1);
    step(1'($urandom_range(1)), W'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < hold; i++)
      step(1'($urandom_range(1)), W'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'($urandom_range(1)), W'($urandom), 1'b1, ab_on_ready, 1'b0);
    n_tensor++;
    $display("[TB] tensor %0d: hold=%0d abort=%0d frames=%0d accepts=%0d",
             n_tensor, hold, ab_on_ready, m_frames, n_acc);
  endtask

  initial begin
    int pulses;
    int guard;
    bit prev_tv;
    n_acc = 0; n_wr = 0; n_tensor = 0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.tensor_ready = 1'b0;
    bus_s.s_valid = 1'b0; bus_s.s_data = '0; bus_s.tensor_ready = 1'b0;
    abort_m = 1'b0;
    rst = 1'b1;
    rst_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_phase = 0; m_count = 0; m_frames = 0; m_pend = 1'b0;
    // Reset state check plus a couple of idle cycles.
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_wr_data", 64'(bus.wr_data), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Full-rate stream with data = index.
    load_tensor(0, 1'b1, -1, -1);
    finish_tensor(3, 1'b0);
    // Random bubbles and random data.
    for (int t = 0; t < 3; t++) begin
      load_tensor(50, 1'b0, -1, -1);
      finish_tensor($urandom_range(0, 4), 1'b0);
    end
    // Reset after 100 accepts, then a full tensor.
    load_tensor(0, 1'b1, 100, -1);
    finish_tensor(0, 1'b0);
`ifdef TENSOR_LOAD_CTRL_ABORT_EN
    // Abort on accept #50, then abort colliding with tensor_ready.
    load_tensor(0, 1'b1, -1, 50);
    finish_tensor(1, 1'b1);
    load_tensor(30, 1'b0, -1, -1);
    finish_tensor(0, 1'b0);
`endif
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("wr_vs_accepts", 64'(n_wr), 64'(n_acc));

    // 1x1x1 instance: tensor_ready always high, frame_cnt must wrap.
    bus_s.s_valid = 1'b1;
    bus_s.tensor_ready = 1'b1;
    rst_s = 1'b0;
    pulses = 0;
    guard = 0;
    prev_tv = 1'b0;
    while (pulses < 256 && guard < 1200) begin
      @(negedge clk);
      guard++;
      if (bus_s.tensor_valid) begin
        check("s_single_pulse", 64'(prev_tv), 64'd0);
        check("s_frame_cnt", 64'(frame_cnt_s), 64'(pulses % 256));
        pulses++;
      end
      prev_tv = bus_s.tensor_valid;
    end
    check("s_pulses", 64'(pulses), 64'd256);
    @(negedge clk);
    check("s_frame_wrap", 64'(frame_cnt_s), 64'd0);
    check("s_elem_cnt", 64'(elem_cnt_s), 64'd0);
    $display("[TB] wrap test: %0d tensor_valid pulses, frame_cnt=%0d", pulses, frame_cnt_s);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tensor_load_ctrl.md
# tensor_load_ctrl

Sequencer that fills the 8×8×3 tensor register array from a valid/ready element stream and hands the completed tensor to a downstream consumer. It generates row/column/channel write addresses in raster order (channel fastest), drives the tensor builder's write port, and holds off new input until the consumer acknowledges the full tensor. It sits between the input stream source and `tensor_builder`, with the consumer on its `tensor_valid`/`tensor_ready` side.

## Interface
- `WIDTH`, 17, element data width; must match the builder.
- `ROWS`, 8, rows per tensor, 1..8.
- `COLS`, 8, columns per tensor, 1..8.
- `CHANS`, 3, channels per element position, 1..4.

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `s_valid` input 1: input element valid.
- `s_ready` output 1: controller accepts element.
- `s_data` input WIDTH: input element.
- `wr_en` output 1: builder write strobe.
- `row_addr` output 3: builder row address.
- `col_addr` output 3: builder column address.
- `cha_addr` output 2: builder channel address.
- `wr_data` output WIDTH: builder write data.
- `tensor_valid` output 1: full tensor present in builder.
- `tensor_ready` input 1: consumer has taken tensor.
- `elem_cnt` output 8: elements accepted in current tensor.
- `frame_cnt` output 8: tensors completed, wraps 255→0.
- `abort` input 1: only with `TENSOR_LOAD_CTRL_ABORT_EN`.

## Operation
- States: LOAD, DRAIN, HOLD. Reset state LOAD.
- Accept = `s_valid && s_ready`. `s_ready = (state == LOAD)`, combinational from state only. It has no dependence on `s_valid`.
- Address order: `cha` increments first 0..CHANS-1, then `col` 0..COLS-1, then `row` 0..ROWS-1. Total N = ROWS·COLS·CHANS elements (192 by default).
- Per accept: register `wr_en=1`, the current address, and `s_data` for one cycle. Then advance the counters. `elem_cnt` increments.
- LOAD→DRAIN on accept of the last element (row=ROWS-1, col=COLS-1, cha=CHANS-1). Counters wrap to 0 and `elem_cnt` clears to 0.
- DRAIN→HOLD unconditionally after one cycle. The last write is issued during DRAIN.
- HOLD: `tensor_valid=1`. HOLD→LOAD on the cycle `tensor_ready=1`. `frame_cnt` increments on that same edge.
- `tensor_ready` is ignored outside HOLD.
- Bubbles (`s_valid=0` in LOAD) leave counters unchanged, and `wr_en=0` the next cycle.
- Reset mid-operation: state LOAD, all counters 0, `wr_en=0`. Partially written builder contents are stale; the next tensor overwrites every entry.
- Reset values: `s_ready=1` (LOAD), `wr_en=0`, `row_addr/col_addr/cha_addr=0`, `wr_data=0`, `tensor_valid=0`, `elem_cnt=0`, `frame_cnt=0`.

## Timing
- Accept at edge T → `wr_en` with that element's address and data during cycle T+1. The builder stores it at the end of T+1.
- Last accept at T → state is DRAIN during T+1 (last write, `s_ready=0`). State is HOLD with `tensor_valid=1` from T+2.
- `tensor_ready` sampled high at edge H → `tensor_valid=0` and `s_ready=1` from H+1. The earliest next accept is at edge H+1.
- Full-rate stream: N accepts in N consecutive cycles. Tensor period is N+2+(HOLD cycles).
- `wr_en`, address and data outputs are registered. `s_ready` and `tensor_valid` decode from state registers.

## Configuration
- Macro: `TENSOR_LOAD_CTRL_ABORT_EN`.
- Defined: `abort` port exists. Abort high at any edge (any state) → next state LOAD, counters and `elem_cnt` cleared, `wr_en=0` next cycle, `frame_cnt` unchanged.
  - Abort wins over a simultaneous accept; that element is dropped.
  - Abort wins over a simultaneous `tensor_ready`; `frame_cnt` does not increment.
- Undefined: no `abort` port, no abort logic.

## Structure
- Shared package `tensor_pkg`:
  - State enum `tlc_state_t` (LOAD, DRAIN, HOLD).
  - Default constants `TENSOR_ROWS=8`, `TENSOR_COLS=8`, `TENSOR_CHANS=3`.
  - Address widths `ROW_AW=3`, `COL_AW=3`, `CHA_AW=2`.
  - Default `TENSOR_WIDTH=17`.
- One sub-module: `tensor_addr_gen`, the nested cha/col/row counter with an `inc` input, `clr` input, and `last` output. The FSM and output registers live in the top module.

## Test plan
- Continuous stream, `s_data`=index 0..191 → 192 consecutive `wr_en` pulses.
  - First write (0,0,0) data 0; write 3 at (0,1,0); last write (7,7,2) data 191.
  - `tensor_valid` rises 2 cycles after the last accept; `s_ready=0` throughout DRAIN/HOLD.
- Random `s_valid` bubbles (50%) → same address/data sequence. `wr_en` count equals accept count, and no address is skipped or repeated.
- `tensor_ready` held high permanently → `tensor_valid` lasts exactly 1 cycle per tensor, and `frame_cnt` increments once per tensor. After 256 tensors (reduced ROWS=COLS=1, CHANS=1) `frame_cnt` returns to 0.
- `rst` asserted after 100 accepts → next cycle `elem_cnt=0`, `wr_en=0`, `s_ready=1`. The next accept writes (0,0,0).
- With `TENSOR_LOAD_CTRL_ABORT_EN`, abort coincident with accept #50 → element 50 not written, `elem_cnt=0`. The next accept writes (0,0,0) and `frame_cnt` is unchanged.
- `tensor_ready` pulsed during LOAD and DRAIN → ignored. HOLD persists until `tensor_ready` is high in HOLD.
